// File: rtl/axi4_slave_multiplier.sv
// axi4_slave_multiplier: AXI4-subset byte-burst responder for operand registers A/B and their product.
// Define AXI4_SLV_STRICT_LEN_EN to reject write bursts that are not exactly SZ/DSZ beats long.
module axi4_slave_multiplier #(
    parameter int SZ  = 32,
    parameter int ASZ = 2,
    parameter int DSZ = 8
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic [ASZ-1:0]    awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DSZ-1:0]    wdata,
    input  logic              wvalid,
    output logic              wready,
    input  logic              wlast,
    output logic              bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ASZ-1:0]    araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [DSZ-1:0]    rdata,
    output logic              rvalid,
    input  logic              rready,
    output logic              rlast,
    output logic              rresp,
    output logic [SZ-1:0]     a_o,
    output logic [SZ-1:0]     b_o,
    output logic [2*SZ-1:0]   res_o
);
    localparam int NB = SZ / DSZ;
    localparam int CW = $clog2(NB + 1);
    localparam int RW = $clog2(NB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t        ws, ws_nxt;
    rstate_t        rs, rs_nxt;
    logic [ASZ-1:0] waddr;
    logic [CW-1:0]  wcnt;
    logic [RW-1:0]  rcnt;
    logic [SZ-1:0]  stage, stage_nxt, rsh, rword;
    logic           aw_hs, w_hs, b_hs, ar_hs, r_hs, err_now, commit_ok;

    assign awready   = ws == W_IDLE;
    assign wready    = ws == W_DATA;
    assign bvalid    = ws == W_RESP;
    assign arready   = rs == R_IDLE;
    assign rvalid    = rs == R_DATA;
    assign rresp     = rvalid;
    assign rlast     = rvalid && rcnt == RW'(NB - 1);
    assign rdata     = rsh[DSZ-1:0];
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;
    assign b_hs      = bvalid & bready;
    assign ar_hs     = arvalid & arready;
    assign r_hs      = rvalid & rready;
    assign commit_ok = !err_now && waddr < ASZ'(2);

`ifdef AXI4_SLV_STRICT_LEN_EN
    logic len_err;
    // sticky: any beat whose wlast disagrees with "this is beat NB" poisons the burst
    assign err_now = len_err | (wlast != (wcnt == CW'(NB - 1)));
    always_ff @(posedge clk or negedge _rst)
        if (!_rst) len_err <= 1'b0;
        else if (aw_hs) len_err <= 1'b0;
        else if (w_hs) len_err <= err_now;
`else
    assign err_now = 1'b0;
`endif

    // staging with the current beat merged in; beats past NB fall through untouched
    always_comb begin
        stage_nxt = stage;
        for (int k = 0; k < NB; k++)
            if (wcnt == CW'(k)) stage_nxt[k*DSZ +: DSZ] = wdata;
    end

    always_comb begin
        ws_nxt = aw_hs ? W_DATA : (w_hs && wlast) ? W_RESP : b_hs ? W_IDLE : ws;
        rs_nxt = ar_hs ? R_DATA : (r_hs && rlast) ? R_IDLE : rs;
        rword  = araddr == ASZ'(0) ? a_o : araddr == ASZ'(1) ? b_o :
                 araddr == ASZ'(2) ? res_o[SZ-1:0] : res_o[2*SZ-1:SZ];
    end

    always_ff @(posedge clk or negedge _rst)
        if (!_rst) begin
            ws    <= W_IDLE;
            waddr <= '0;
            wcnt  <= '0;
            stage <= '0;
            bresp <= 1'b0;
            a_o   <= '0;
            b_o   <= '0;
            res_o <= '0;
        end else begin
            ws    <= ws_nxt;
            res_o <= a_o * b_o;
            if (aw_hs) begin
                waddr <= awaddr;
                wcnt  <= '0;
                stage <= '0;
            end
            if (w_hs) begin
                stage <= stage_nxt;
                if (wcnt != CW'(NB)) wcnt <= wcnt + 1'b1;
            end
            if (w_hs && wlast) begin
                bresp <= commit_ok;
                if (commit_ok && waddr == ASZ'(0)) a_o <= stage_nxt;
                if (commit_ok && waddr == ASZ'(1)) b_o <= stage_nxt;
            end
            if (b_hs) bresp <= 1'b0;
        end

    always_ff @(posedge clk or negedge _rst)
        if (!_rst) begin
            rs   <= R_IDLE;
            rsh  <= '0;
            rcnt <= '0;
        end else begin
            rs <= rs_nxt;
            if (ar_hs) begin
                rsh  <= rword;
                rcnt <= '0;
            end else if (r_hs) begin
                rsh  <= rlast ? '0 : rsh >> DSZ;
                rcnt <= rcnt + 1'b1;
            end
        end
endmodule

// File: tb/tb_axi4_slave_multiplier.sv
// tb_axi4_slave_multiplier: directed plus random bursts checked against a word-level register model.
module tb_axi4_slave_multiplier;
    logic        clk = 1'b0, _rst;
    logic [1:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, wlast, bresp, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast, rresp;
    logic [7:0]  wdata, rdata;
    logic [31:0] a_o, b_o;
    logic [63:0] res_o;
    int          checks = 0, errors = 0;
    logic [31:0] ma = '0, mb = '0;
`ifdef AXI4_SLV_STRICT_LEN_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    axi4_slave_multiplier dut (
        .clk(clk), ._rst(_rst),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast), .rresp(rresp),
        .a_o(a_o), .b_o(b_o), .res_o(res_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] prod();
        return 64'(ma) * 64'(mb);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_awready"}, 64'(awready), 64'd1);
        check({tag, "_arready"}, 64'(arready), 64'd1);
        check({tag, "_wready"},  64'(wready),  64'd0);
        check({tag, "_bvalid"},  64'(bvalid),  64'd0);
        check({tag, "_rvalid"},  64'(rvalid),  64'd0);
        check({tag, "_rlast"},   64'(rlast),   64'd0);
        check({tag, "_rdata"},   64'(rdata),   64'd0);
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [7:0] d[5], input int n, input string tag);
        int cyc;
        logic ok;
        logic [31:0] w;
        logic [63:0] old_res;
        awaddr = addr; awvalid = 1'b1; cyc = 0;
        while (!awready && cyc < 20) begin step(); cyc++; end
        check({tag, "_awready"}, 64'(awready), 64'd1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i < n; i++) begin
            wdata = d[i]; wvalid = 1'b1; wlast = (i == n - 1); cyc = 0;
            while (!wready && cyc < 20) begin step(); cyc++; end
            if (i == 0) check({tag, "_wready"}, 64'(wready), 64'd1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        ok = addr < 2'd2 && (!STRICT || n == 4);
        w = '0;
        for (int j = 0; j < n && j < 4; j++) w[8*j +: 8] = d[j];
        old_res = prod();
        if (ok && addr == 2'd0) ma = w;
        if (ok && addr == 2'd1) mb = w;
        check({tag, "_bvalid"}, 64'(bvalid), 64'd1);
        check({tag, "_bresp"},  64'(bresp),  64'(ok));
        check({tag, "_a"},      64'(a_o),    64'(ma));
        check({tag, "_b"},      64'(b_o),    64'(mb));
        check({tag, "_res_old"}, res_o,      old_res);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check({tag, "_bdone"},  64'(bvalid), 64'd0);
        check({tag, "_res"},    res_o,       prod());
        check({tag, "_awrdy"},  64'(awready), 64'd1);
    endtask

    // mode 0: rready always high, 1: toggling 1,0,1,0.., 2: random
    task automatic do_read(input logic [1:0] addr, input int mode, input string tag);
        int cyc, k;
        logic [31:0] w;
        logic [63:0] p;
        p = prod();
        w = addr == 2'd0 ? ma : addr == 2'd1 ? mb : addr == 2'd2 ? p[31:0] : p[63:32];
        araddr = addr; arvalid = 1'b1; cyc = 0;
        while (!arready && cyc < 20) begin step(); cyc++; end
        check({tag, "_arready"}, 64'(arready), 64'd1);
        step();
        arvalid = 1'b0; k = 0; cyc = 0;
        while (k < 4 && cyc < 40) begin
            rready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            check({tag, "_rvalid"}, 64'(rvalid), 64'd1);
            check({tag, "_rdata"},  64'(rdata),  64'(8'(w >> (8 * k))));
            check({tag, "_rlast"},  64'(rlast),  64'(k == 3));
            check({tag, "_rresp"},  64'(rresp),  64'd1);
            if (rready) k++;
            step();
            cyc++;
        end
        rready = 1'b0;
        check({tag, "_beats"}, 64'(k), 64'd4);
        check({tag, "_rdone"}, 64'(rvalid), 64'd0);
        check({tag, "_rlast0"}, 64'(rlast), 64'd0);
        check({tag, "_rdata0"}, 64'(rdata), 64'd0);
        check({tag, "_arrdy"}, 64'(arready), 64'd1);
    endtask

    initial begin
        logic [7:0] d[5];
        _rst = 1'b0; awaddr = '0; awvalid = 0; wdata = '0; wvalid = 0; wlast = 0;
        bready = 0; araddr = '0; arvalid = 0; rready = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        check("reset_a", 64'(a_o), 64'd0);
        check("reset_res", res_o, 64'd0);
        check("reset_bresp", 64'(bresp), 64'd0);
        _rst = 1'b1;
        step();

        do_write(2'd0, '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00}, 4, "t1_wa");
        do_write(2'd1, '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00}, 4, "t1_wb");
        check("t1_res_const", res_o, 64'h2468ACF0);
        do_read(2'd2, 0, "t2_lo");
        do_read(2'd3, 0, "t2_hi");
        do_write(2'd3, '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00}, 4, "t3_ro");
        do_read(2'd0, 1, "t4_tog");

        awaddr = 2'd0; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin wdata = 8'hA5; wvalid = 1'b1; step(); end
        wvalid = 1'b0;
        step();
        #2 _rst = 1'b0;
        #1;
        ma = '0; mb = '0;
        check_idle("t5_rst");
        check("t5_a", 64'(a_o), 64'd0);
        check("t5_res", res_o, 64'd0);
        step();
        _rst = 1'b1;
        step();
        check("t5_awready", 64'(awready), 64'd1);
        check("t5_a_after", 64'(a_o), 64'd0);

        do_write(2'd1, '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55}, 4, "t6_pre");
        do_write(2'd1, '{8'hC3, 8'h5A, 8'h00, 8'h00, 8'h00}, 2, "t6_short");
        check("t6_b_const", 64'(b_o), STRICT ? 64'h44332211 : 64'h00005AC3);

        for (int it = 0; it < 25; it++) begin
            for (int j = 0; j < 5; j++) d[j] = 8'($urandom);
            do_write(2'($urandom_range(0, 3)), d, int'($urandom_range(1, 5)), "rnd_w");
            do_read(2'($urandom_range(0, 3)), 2, "rnd_r");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
